// File: rtl/music_seq.sv
// Melody sequencer: turns one-cycle game events into timed tone-index sequences for the Buzzer.
// Optional background loop in idle is enabled by defining MUSIC_SEQ_BGM_EN (adds port i_bgm_on).
module music_seq #(
  parameter int NOTE_CYC = 25_000_000,
  parameter int GAP_CYC  = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load_done,
  input  logic       i_perfect,
  input  logic       i_gameover,
`ifdef MUSIC_SEQ_BGM_EN
  input  logic       i_bgm_on,
`endif
  output logic [5:0] music_scale,
  output logic       o_busy,
  output logic       o_melody_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_NOTE, ST_GAP} state_t;
  // Encoding order doubles as priority: a larger value preempts a smaller one.
  typedef enum logic [1:0] {MEL_BGM, MEL_LAND, MEL_PERFECT, MEL_GAMEOVER} melody_t;

  localparam int EV_LOAD  = 0;
  localparam int EV_GOVER = 1;

  localparam logic [31:0] NOTE_LEN  = 32'(NOTE_CYC);
  localparam logic [31:0] NOTE_LEN2 = 32'(2 * NOTE_CYC);
  localparam logic [31:0] GAP_LEN   = 32'(GAP_CYC);

  state_t      state_reg, state_next;
  melody_t     mel_reg, mel_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [5:0]  scale_reg, scale_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;

  logic [1:0]  evt_in, evt_prev_reg, evt_edge;
  logic        bgm_on;
  logic        trig_valid;
  melody_t     trig_mel;
  logic        playing_event;
  logic        accept;
  logic [31:0] cur_len;
  logic [1:0]  idx_inc;

`ifdef MUSIC_SEQ_BGM_EN
  assign bgm_on = i_bgm_on;
`else
  assign bgm_on = 1'b0;
`endif

  assign evt_in = {i_gameover, i_load_done};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      assign evt_edge[gi] = evt_in[gi] & ~evt_prev_reg[gi];
    end
  endgenerate

  function automatic logic [5:0] rom_note(input melody_t mel, input logic [1:0] idx);
    logic [5:0] note;
    note = 6'd0;
    case (mel)
      MEL_LAND: begin
        case (idx)
          2'd0:    note = 6'd8;
          2'd1:    note = 6'd10;
          default: note = 6'd0;
        endcase
      end
      MEL_PERFECT: begin
        case (idx)
          2'd0:    note = 6'd8;
          2'd1:    note = 6'd10;
          2'd2:    note = 6'd12;
          default: note = 6'd15;
        endcase
      end
      MEL_GAMEOVER: begin
        case (idx)
          2'd0:    note = 6'd12;
          2'd1:    note = 6'd10;
          2'd2:    note = 6'd8;
          default: note = 6'd1;
        endcase
      end
      default: begin
        case (idx)
          2'd0:    note = 6'd8;
          2'd1:    note = 6'd12;
          2'd2:    note = 6'd10;
          default: note = 6'd12;
        endcase
      end
    endcase
    return note;
  endfunction

  function automatic logic is_last(input melody_t mel, input logic [1:0] idx);
    return (mel == MEL_LAND) ? (idx == 2'd1) : (idx == 2'd3);
  endfunction

  function automatic logic [31:0] note_len(input melody_t mel, input logic [1:0] idx);
    logic [31:0] len;
    len = NOTE_LEN;
    if (mel == MEL_BGM || (mel == MEL_GAMEOVER && idx == 2'd3)) begin
      len = NOTE_LEN2;
    end
    return len;
  endfunction

  always_comb begin
    trig_valid = 1'b0;
    trig_mel   = MEL_LAND;
    if (evt_edge[EV_GOVER]) begin
      trig_valid = 1'b1;
      trig_mel   = MEL_GAMEOVER;
    end else if (evt_edge[EV_LOAD]) begin
      trig_valid = 1'b1;
      trig_mel   = i_perfect ? MEL_PERFECT : MEL_LAND;
    end
  end

  // The background loop never blocks an event; only a real melody can.
  assign playing_event = (state_reg != ST_IDLE) && (mel_reg != MEL_BGM);
  assign accept = trig_valid &&
                  (!playing_event || (trig_mel > mel_reg) ||
                   (trig_mel == MEL_LAND && mel_reg == MEL_LAND));

  assign cur_len = note_len(mel_reg, idx_reg);
  assign idx_inc = idx_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    mel_next   = mel_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    scale_next = scale_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (accept) begin
      state_next = ST_NOTE;
      mel_next   = trig_mel;
      idx_next   = 2'd0;
      cnt_next   = 32'd0;
      scale_next = rom_note(trig_mel, 2'd0);
      busy_next  = 1'b1;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          busy_next = 1'b0;
          if (bgm_on) begin
            state_next = ST_NOTE;
            mel_next   = MEL_BGM;
            idx_next   = 2'd0;
            cnt_next   = 32'd0;
            scale_next = rom_note(MEL_BGM, 2'd0);
          end else begin
            scale_next = 6'd0;
          end
        end

        ST_NOTE: begin
          if (mel_reg == MEL_BGM && !bgm_on) begin
            state_next = ST_IDLE;
            scale_next = 6'd0;
            cnt_next   = 32'd0;
          end else if (cnt_reg == cur_len - 32'd1) begin
            cnt_next   = 32'd0;
            scale_next = 6'd0;
            // The background loop gaps after its last note too, then wraps.
            if (is_last(mel_reg, idx_reg) && mel_reg != MEL_BGM) begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              state_next = ST_GAP;
            end
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end

        ST_GAP: begin
          if (mel_reg == MEL_BGM && !bgm_on) begin
            state_next = ST_IDLE;
            scale_next = 6'd0;
            cnt_next   = 32'd0;
          end else if (cnt_reg == GAP_LEN - 32'd1) begin
            state_next = ST_NOTE;
            idx_next   = idx_inc;
            cnt_next   = 32'd0;
            scale_next = rom_note(mel_reg, idx_inc);
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end

        default: begin
          state_next = ST_IDLE;
          scale_next = 6'd0;
          busy_next  = 1'b0;
          cnt_next   = 32'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      mel_reg      <= MEL_LAND;
      idx_reg      <= 2'd0;
      cnt_reg      <= 32'd0;
      scale_reg    <= 6'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      // Held-high inputs must not look like fresh edges once reset releases.
      evt_prev_reg <= 2'b11;
    end else begin
      state_reg    <= state_next;
      mel_reg      <= mel_next;
      idx_reg      <= idx_next;
      cnt_reg      <= cnt_next;
      scale_reg    <= scale_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      evt_prev_reg <= evt_in;
    end
  end

  assign music_scale   = scale_reg;
  assign o_busy        = busy_reg;
  assign o_melody_done = done_reg;

endmodule

// File: tb/tb_music_seq.sv
// Self-checking bench for music_seq: directed vector table, hand sequence, and random
// stimulus compared each cycle against a per-cycle timeline model built from the melody rules.
module tb_music_seq;

  localparam int NOTE = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       rst;
  logic       i_load_done;
  logic       i_perfect;
  logic       i_gameover;
  logic [5:0] music_scale;
  logic       o_busy;
  logic       o_melody_done;
`ifdef MUSIC_SEQ_BGM_EN
  logic       bgm_on;
`endif

  music_seq #(.NOTE_CYC(NOTE), .GAP_CYC(GAP)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_load_done  (i_load_done),
    .i_perfect    (i_perfect),
    .i_gameover   (i_gameover),
`ifdef MUSIC_SEQ_BGM_EN
    .i_bgm_on     (bgm_on),
`endif
    .music_scale  (music_scale),
    .o_busy       (o_busy),
    .o_melody_done(o_melody_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: the whole remaining output timeline of the active melody, one entry per cycle,
  // packed as {done, busy, scale}.
  logic [7:0] tl_q[$];
  logic       m_prev_ld, m_prev_go, m_busy;
  int         m_mel;
  logic [5:0] exp_scale;
  logic       exp_busy, exp_done;
  logic       quiet;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // mel: 1 = LAND, 2 = PERFECT, 3 = GAMEOVER
  task automatic build_timeline(input int mel);
    int notes[4];
    int n;
    tl_q.delete();
    case (mel)
      1:       begin notes = '{8, 10, 0, 0};  n = 2; end
      2:       begin notes = '{8, 10, 12, 15}; n = 4; end
      default: begin notes = '{12, 10, 8, 1}; n = 4; end
    endcase
    for (int i = 0; i < n; i++) begin
      int len;
      len = (mel == 3 && i == n - 1) ? 2 * NOTE : NOTE;
      for (int c = 0; c < len; c++) tl_q.push_back({1'b0, 1'b1, 6'(notes[i])});
      if (i != n - 1)
        for (int c = 0; c < GAP; c++) tl_q.push_back({1'b0, 1'b1, 6'd0});
    end
    tl_q.push_back({1'b1, 1'b0, 6'd0});
  endtask

  task automatic model_edge(input logic ld, input logic pf, input logic go, input logic rs);
    logic [7:0] e;
    int new_mel;
    if (rs) begin
      tl_q.delete();
      m_prev_ld = 1'b1;
      m_prev_go = 1'b1;
      m_busy    = 1'b0;
      e = 8'd0;
    end else begin
      new_mel = 0;
      if (go && !m_prev_go)      new_mel = 3;
      else if (ld && !m_prev_ld) new_mel = pf ? 2 : 1;
      if (new_mel != 0 && (!m_busy || new_mel > m_mel || (new_mel == 1 && m_mel == 1))) begin
        build_timeline(new_mel);
        m_mel = new_mel;
        if (!quiet) $display("t=%0t melody %0d started", $time, new_mel);
      end
      m_prev_ld = ld;
      m_prev_go = go;
      e = (tl_q.size() > 0) ? tl_q.pop_front() : 8'd0;
      m_busy = e[6];
    end
    exp_scale = e[5:0];
    exp_busy  = e[6];
    exp_done  = e[7];
  endtask

  task automatic step(input logic ld, input logic pf, input logic go, input logic rs);
    i_load_done = ld;
    i_perfect   = pf;
    i_gameover  = go;
    rst         = rs;
    @(posedge clk);
    model_edge(ld, pf, go, rs);
    #1;
    chk("model_scale", int'(music_scale), int'(exp_scale));
    chk("model_busy", int'(o_busy), int'(exp_busy));
    chk("model_done", int'(o_melody_done), int'(exp_done));
    chk("scale_range", int'(music_scale <= 6'd21), 1);
  endtask

  typedef struct packed {
    logic        ld;
    logic        pf;
    logic        go;
    logic        rs;
    logic [15:0] cyc;
    logic [5:0]  scale;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic pf, input logic go, input logic rs,
                     input int cyc, input int scale, input logic busy, input logic done);
    vecs.push_back('{ld, pf, go, rs, 16'(cyc), 6'(scale), busy, done});
  endtask

  initial begin
    int busy_cnt, done_cnt;
    logic ld, pf, go, rs;

    rst = 1'b1; i_load_done = 1'b0; i_perfect = 1'b0; i_gameover = 1'b0;
    quiet = 1'b0;
`ifdef MUSIC_SEQ_BGM_EN
    bgm_on = 1'b0;
`endif
    m_prev_ld = 1'b1; m_prev_go = 1'b1; m_busy = 1'b0; m_mel = 0;

    //   ld    pf    go    rs  cyc scale busy  done
    add(1'b0, 1'b0, 1'b0, 1'b1, 2,  0, 1'b0, 1'b0); // reset state
    add(1'b0, 1'b0, 1'b0, 1'b0, 2,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1,  8, 1'b1, 1'b0); // LAND, one-cycle latency
    add(1'b1, 1'b0, 1'b0, 1'b0, 3,  8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b1, 1'b0); // gap
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1, 10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 3, 10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b1); // done pulse
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1,  8, 1'b1, 1'b0); // PERFECT
    add(1'b1, 1'b1, 1'b0, 1'b0, 4,  0, 1'b1, 1'b0); // held high, no retrigger
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1, 10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 6, 12, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 2, 12, 1'b1, 1'b0); // inside 3rd note
    add(1'b0, 1'b0, 1'b1, 1'b0, 1, 12, 1'b1, 1'b0); // GAMEOVER preempts
    add(1'b0, 1'b0, 1'b1, 1'b0,17,  0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1,  1, 1'b1, 1'b0); // LAND ignored during GAMEOVER
    add(1'b0, 1'b0, 1'b0, 1'b0, 7,  1, 1'b1, 1'b0); // final note held 8 cycles
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1, 12, 1'b1, 1'b0); // simultaneous edges
    add(1'b0, 1'b0, 1'b0, 1'b0,26,  0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1,  8, 1'b1, 1'b0); // LAND then reset mid-melody
    add(1'b1, 1'b0, 1'b0, 1'b1, 1,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 3,  0, 1'b0, 1'b0); // no retrigger after release
    add(1'b0, 1'b0, 1'b0, 1'b0, 2,  0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1,  8, 1'b1, 1'b0); // LAND restarts LAND
    add(1'b0, 1'b0, 1'b0, 1'b0, 5,  0, 1'b1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1,  8, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 9, 10, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1,  0, 1'b0, 1'b0);

    for (int v = 0; v < vecs.size(); v++) begin
      for (int c = 0; c < int'(vecs[v].cyc); c++)
        step(vecs[v].ld, vecs[v].pf, vecs[v].go, vecs[v].rs);
      chk("vec_scale", int'(music_scale), int'(vecs[v].scale));
      chk("vec_busy", int'(o_busy), int'(vecs[v].busy));
      chk("vec_done", int'(o_melody_done), int'(vecs[v].done));
      $display("vec %0d: ld=%0b pf=%0b go=%0b rst=%0b x%0d -> scale=%0d busy=%0b done=%0b",
               v, vecs[v].ld, vecs[v].pf, vecs[v].go, vecs[v].rs, vecs[v].cyc,
               music_scale, o_busy, o_melody_done);
    end

    // PERFECT with a 5-cycle pulse: busy length and single done pulse
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 35; c++) begin
      step(c < 5, c < 5, 1'b0, 1'b0);
      busy_cnt += int'(o_busy);
      done_cnt += int'(o_melody_done);
    end
    chk("perfect_busy_cycles", busy_cnt, 22);
    chk("perfect_done_pulses", done_cnt, 1);
    $display("perfect run: busy=%0d cycles, done pulses=%0d", busy_cnt, done_cnt);

    // Random stimulus against the timeline model
    ld = 1'b0; pf = 1'b0; go = 1'b0; rs = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 14) == 0) ld = ~ld;
      if ($urandom_range(0, 49) == 0) go = ~go;
      pf = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 399) == 0);
      step(ld, pf, go, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/music_seq.md
Name: music_seq

Overview:
- Melody sequencer that drives the Buzzer's music_scale input.
- Converts one-cycle game events (landing, perfect landing, game over) into timed note sequences.
- Sits between the game-logic FSM and the Buzzer; the Buzzer only renders the tone index this block presents.
- One tone index is shown at a time; higher-priority events preempt lower ones.

Parameters:
- NOTE_CYC, 25_000_000, clock cycles per note (250 ms at 100 MHz); must be >= 1.
- GAP_CYC, 2_500_000, silent cycles inserted after each non-final note; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- i_load_done  in  1  player landed on box; rising edge triggers.
- i_perfect  in  1  level qualifier, sampled on the i_load_done rising edge.
- i_gameover  in  1  game over; rising edge triggers.
- music_scale  out  6  tone index to Buzzer: 0 = silence, 1-7 low do..si, 8-14 mid, 15-21 high.
- o_busy  out  1  high while a melody is playing.
- o_melody_done  out  1  one-cycle pulse when a melody completes naturally.

Behaviour:
- Reset behaviour:
  - On rst=1 at a clk edge: music_scale=0, o_busy=0, o_melody_done=0, state IDLE, counters 0.
  - Edge-detect history registers are set to 1, so an input held high through reset does not trigger.
  - Reset mid-melody aborts it with no done pulse.
- Edge detection: trigger when the registered previous value is 0 and the current value is 1.
- Melody selection on a trigger:
  - i_gameover edge → GAMEOVER.
  - Otherwise, i_load_done edge with i_perfect=1 → PERFECT.
  - Otherwise, i_load_done edge → LAND.
- Melody ROM, as notes in order:
  - LAND: 8, 10.
  - PERFECT: 8, 10, 12, 15.
  - GAMEOVER: 12, 10, 8, 1. The final note is held 2*NOTE_CYC.
- State machine:
  - States: IDLE → NOTE → (GAP → NOTE)* → IDLE.
  - NOTE: music_scale = ROM note for NOTE_CYC cycles (2*NOTE_CYC for the GAMEOVER final note).
  - GAP: music_scale = 0 for GAP_CYC cycles. There is no gap after the final note.
  - On final-note expiry: music_scale → 0, o_busy → 0, and o_melody_done=1 for exactly that cycle.
- Latency: first note is visible on music_scale one cycle after the cycle in which the rising edge is sampled. o_busy rises in that same cycle.
- Priority and preemption (priority GAMEOVER > PERFECT > LAND):
  - A new trigger of strictly higher priority restarts at note 0 of the new melody, one-cycle latency, no done pulse for the aborted melody.
  - A LAND trigger during LAND restarts LAND.
  - Equal- or lower-priority triggers are otherwise ignored (PERFECT during PERFECT, LAND during PERFECT, anything during GAMEOVER).
  - Simultaneous i_gameover and i_load_done edges → GAMEOVER only.
- All outputs are registered; music_scale never takes values 22-63.
- Duration counter is 32-bit, counts 0..len-1, then advances.

Optional Feature:
- Macro: MUSIC_SEQ_BGM_EN.
- When defined:
  - Adds input port i_bgm_on (1 bit).
  - In IDLE with i_bgm_on=1, loops background melody 8, 12, 10, 12 at 2*NOTE_CYC per note, with GAP_CYC gaps, including after the last note before wrapping.
  - o_busy stays 0 and o_melody_done never pulses for the background melody.
  - Any event preempts it; it restarts at note 0 one cycle after the event melody ends (if i_bgm_on=1).
  - i_bgm_on=0 silences it next cycle.
- When undefined: no port, and IDLE is always silent.

Test Plan (NOTE_CYC=4, GAP_CYC=2):
- LAND: i_load_done 0→1 with i_perfect=0 → one cycle later music_scale=8 for 4 cycles, 0 for 2, 10 for 4, then 0. o_busy high 10 cycles. o_melody_done pulses once as music_scale returns to 0.
- PERFECT: i_load_done edge with i_perfect=1, pulse held 5 cycles → notes 8, 10, 12, 15 with 2-cycle gaps. o_busy high 22 cycles. Only one melody, since the level hold does not retrigger.
- Preempt: i_gameover edge during the 3rd PERFECT note → next cycle music_scale=12, then GAMEOVER runs fully with last note 1 held 8 cycles. Exactly one o_melody_done pulse.
- Simultaneous i_load_done and i_gameover edges → GAMEOVER sequence only. A LAND trigger mid-GAMEOVER is ignored.
- Reset mid-LAND (rst=1 one cycle, i_load_done still high) → music_scale=0, o_busy=0 next cycle. No retrigger after release. No done pulse.
- With MUSIC_SEQ_BGM_EN and i_bgm_on=1, idle → music_scale loops 8, 12, 10, 12 (8 cycles each, 2-cycle gaps) with o_busy=0. LAND event interrupts, and BGM resumes at 8 one cycle after o_melody_done.
